// File: rtl/mul_restore.sv
// mul_restore -- sequential shift-add reconstruction of a division result.
//
// Rebuilds Product = Quotient * Divisor + Reminder one multiplier bit per
// clock, then compares it against the zero-extended Dividend. The operation
// uses the same level-start / one-cycle-done handshake as the divider.
//
// State table
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for Start_Sig; operands are latched on the start edge
//   MUL   | one shift-add iteration per clock, DATA_W iterations
//   ADD   | add Reminder, load Product/Match_Sig, raise Done_Sig
//   DONE  | Done_Sig cleared; always moves on to HOLD
//   HOLD  | waits for Start_Sig to drop so a held start cannot retrigger
//
// Ports
//   CLK        system clock, rising edge
//   RSTn       asynchronous active-low reset
//   Start_Sig  level start request, sampled only in IDLE
//   Quotient   multiplier operand (unsigned)
//   Divisor    multiplicand operand (unsigned)
//   Reminder   addend (unsigned, zero-extended)
//   Dividend   expected result for the compare (unsigned, zero-extended)
//   Done_Sig   one-cycle completion pulse
//   Product    reconstructed value, 2*DATA_W bits, held until next ADD
//   Match_Sig  Product == zero-extended Dividend, updated with Done_Sig
//   Busy_Sig   high in every state except IDLE

module mul_restore #(
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  Start_Sig,
  input  logic [DATA_W-1:0]     Quotient,
  input  logic [DATA_W-1:0]     Divisor,
  input  logic [DATA_W-1:0]     Reminder,
  input  logic [DATA_W-1:0]     Dividend,
  output logic                  Done_Sig,
  output logic [2*DATA_W-1:0]   Product,
  output logic                  Match_Sig,
  output logic                  Busy_Sig
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ADD  = 3'd2,
    DONE = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mplier;
  logic [PW-1:0]     mcand;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvd_q;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     sum_w;

  // Final sum; the accumulator is wide enough that this cannot overflow.
  assign sum_w = acc + {{DATA_W{1'b0}}, rem_q};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      mplier    <= '0;
      mcand     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      acc       <= '0;
      cnt       <= '0;
      Product   <= '0;
      Match_Sig <= 1'b0;
      Done_Sig  <= 1'b0;
      Busy_Sig  <= 1'b0;
    end else begin
      Done_Sig <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_Sig) begin
            mplier   <= Quotient;
            mcand    <= {{DATA_W{1'b0}}, Divisor};
            rem_q    <= Reminder;
            dvd_q    <= Dividend;
            acc      <= '0;
            cnt      <= '0;
            Busy_Sig <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= ADD;
        end
        ADD: begin
          Product   <= sum_w;
          // Full-width compare, so any nonzero upper half forces a mismatch.
          Match_Sig <= (sum_w == {{DATA_W{1'b0}}, dvd_q});
          Done_Sig  <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!Start_Sig) begin
            Busy_Sig <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          Busy_Sig <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_restore.sv
// Directed testbench for mul_restore (DATA_W = 8).
module tb_mul_restore;

  logic        CLK;
  logic        RSTn;
  logic        Start_Sig;
  logic [7:0]  Quotient;
  logic [7:0]  Divisor;
  logic [7:0]  Reminder;
  logic [7:0]  Dividend;
  logic        Done_Sig;
  logic [15:0] Product;
  logic        Match_Sig;
  logic        Busy_Sig;

  int checks = 0;
  int errors = 0;

  mul_restore #(.DATA_W(8)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Start_Sig (Start_Sig),
    .Quotient  (Quotient),
    .Divisor   (Divisor),
    .Reminder  (Reminder),
    .Dividend  (Dividend),
    .Done_Sig  (Done_Sig),
    .Product   (Product),
    .Match_Sig (Match_Sig),
    .Busy_Sig  (Busy_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Drive operands at a negedge, take the start edge, scramble the inputs,
  // then count edges after the start edge until Done_Sig is seen.
  task automatic do_op(input logic [7:0] q, input logic [7:0] d,
                       input logic [7:0] r, input logic [7:0] dv,
                       input bit keep_start, output int lat);
    Quotient  = q;
    Divisor   = d;
    Reminder  = r;
    Dividend  = dv;
    Start_Sig = 1'b1;
    cyc();
    Quotient  = 8'hA5;
    Divisor   = 8'h5A;
    Reminder  = 8'h3C;
    Dividend  = 8'hC3;
    if (!keep_start) Start_Sig = 1'b0;
    lat = 0;
    while (!Done_Sig && lat < 40) begin
      cyc();
      lat++;
    end
  endtask

  // After the done cycle: pulse must clear, block sits in HOLD, then IDLE.
  task automatic post_done(input string tag);
    cyc();
    chk({tag, "_done_clr"}, 32'(Done_Sig), 32'd0);
    chk({tag, "_busy_hold"}, 32'(Busy_Sig), 32'd1);
    Start_Sig = 1'b0;
    cyc();
    chk({tag, "_busy_idle"}, 32'(Busy_Sig), 32'd0);
  endtask

  int lat;
  int pulses;
  int busy_low;

  initial begin
    RSTn      = 1'b0;
    Start_Sig = 1'b0;
    Quotient  = '0;
    Divisor   = '0;
    Reminder  = '0;
    Dividend  = '0;
    #3;
    chk("rst_product", 32'(Product), 32'd0);
    chk("rst_match", 32'(Match_Sig), 32'd0);
    chk("rst_done", 32'(Done_Sig), 32'd0);
    chk("rst_busy", 32'(Busy_Sig), 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    cyc();

    // 44*5+0 = 220, Start held until done
    do_op(8'd44, 8'd5, 8'd0, 8'd220, 1'b1, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_done", 32'(Done_Sig), 32'd1);
    chk("t1_product", 32'(Product), 32'd220);
    chk("t1_match", 32'(Match_Sig), 32'd1);
    post_done("t1");
    chk("t1_product_held", 32'(Product), 32'd220);

    // 255*255+255 = 65280, upper byte nonzero
    do_op(8'd255, 8'd255, 8'd255, 8'd0, 1'b1, lat);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_product", 32'(Product), 32'd65280);
    chk("t2_match", 32'(Match_Sig), 32'd0);
    post_done("t2");

    // Divisor = 0 -> Reminder only
    do_op(8'd7, 8'd0, 8'd9, 8'd9, 1'b1, lat);
    chk("t3_product", 32'(Product), 32'd9);
    chk("t3_match", 32'(Match_Sig), 32'd1);
    post_done("t3");

    // 10*3+1 = 31 vs 30
    do_op(8'd10, 8'd3, 8'd1, 8'd30, 1'b1, lat);
    chk("t4_product", 32'(Product), 32'd31);
    chk("t4_match", 32'(Match_Sig), 32'd0);
    post_done("t4");

    // Quotient = 0 -> Reminder only
    do_op(8'd0, 8'd9, 8'd5, 8'd5, 1'b1, lat);
    chk("t5_product", 32'(Product), 32'd5);
    chk("t5_match", 32'(Match_Sig), 32'd1);
    post_done("t5");

    // Start dropped right after the start edge: no abort; 200*100+50 = 20050
    do_op(8'd200, 8'd100, 8'd50, 8'd80, 1'b0, lat);
    chk("t6_latency", 32'(lat), 32'd9);
    chk("t6_done", 32'(Done_Sig), 32'd1);
    chk("t6_product", 32'(Product), 32'd20050);
    chk("t6_match", 32'(Match_Sig), 32'd0);
    post_done("t6");

    // Start held 20 cycles past done: single pulse, busy stays high
    do_op(8'd3, 8'd4, 8'd2, 8'd14, 1'b1, lat);
    chk("t7_latency", 32'(lat), 32'd9);
    chk("t7_product", 32'(Product), 32'd14);
    chk("t7_match", 32'(Match_Sig), 32'd1);
    pulses   = 0;
    busy_low = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (Done_Sig) pulses++;
      if (!Busy_Sig) busy_low++;
    end
    chk("t7_extra_pulses", 32'(pulses), 32'd0);
    chk("t7_busy_low_cycles", 32'(busy_low), 32'd0);
    Start_Sig = 1'b0;
    cyc();
    chk("t7_busy_released", 32'(Busy_Sig), 32'd0);
    do_op(8'd6, 8'd7, 8'd0, 8'd42, 1'b1, lat);
    chk("t7_second_latency", 32'(lat), 32'd9);
    chk("t7_second_product", 32'(Product), 32'd42);
    chk("t7_second_match", 32'(Match_Sig), 32'd1);
    post_done("t7b");

    // Reset during MUL iteration 4
    Quotient  = 8'd100;
    Divisor   = 8'd100;
    Reminder  = 8'd0;
    Dividend  = 8'd0;
    Start_Sig = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    RSTn = 1'b0;
    #1;
    chk("t8_rst_product", 32'(Product), 32'd0);
    chk("t8_rst_match", 32'(Match_Sig), 32'd0);
    chk("t8_rst_done", 32'(Done_Sig), 32'd0);
    chk("t8_rst_busy", 32'(Busy_Sig), 32'd0);
    Start_Sig = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (Done_Sig) pulses++;
    end
    chk("t8_no_done", 32'(pulses), 32'd0);
    chk("t8_idle_busy", 32'(Busy_Sig), 32'd0);
    do_op(8'd12, 8'd12, 8'd3, 8'd147, 1'b1, lat);
    chk("t8_latency", 32'(lat), 32'd9);
    chk("t8_product", 32'(Product), 32'd147);
    chk("t8_match", 32'(Match_Sig), 32'd1);
    post_done("t8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_restore.md
MUL_RESTORE -- requirements
Module: mul_restore

Purpose: sequential shift-add checker that rebuilds a division result: Product = Quotient*Divisor + Reminder. It uses the same Start_Sig/Done_Sig handshake as the div block.

Interface
REQ-001 Parameter: DATA_W, default 8, operand width in bits; Product is 2*DATA_W bits wide.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 Start_Sig  input  1  level request; start is sampled only in IDLE.
REQ-005 Quotient  input  DATA_W  multiplier operand, unsigned.
REQ-006 Divisor  input  DATA_W  multiplicand operand, unsigned.
REQ-007 Reminder  input  DATA_W  addend, unsigned, zero-extended.
REQ-008 Dividend  input  DATA_W  expected result, unsigned, zero-extended, used for the compare.
REQ-009 Done_Sig  output  1  one-cycle completion pulse.
REQ-010 Product  output  2*DATA_W  reconstructed value, registered.
REQ-011 Match_Sig  output  1  high when Product equals the zero-extended Dividend; registered with Done_Sig.
REQ-012 Busy_Sig  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, MUL, ADD, DONE and HOLD, encoded in a registered state machine.
REQ-014 IDLE with Start_Sig=1 at an edge (E0): latch Quotient, Divisor, Reminder and Dividend; clear the accumulator and the iteration counter; go to MUL.
REQ-015 MUL, one iteration per edge, DATA_W iterations (E1..E8 for DATA_W=8):
  - if the multiplier LSB is 1, add the shifted multiplicand to the accumulator;
  - shift the multiplier right by 1 and the multiplicand left by 1;
  - increment the counter.
REQ-016 MUL SHALL go to ADD on the edge that completes iteration DATA_W.
REQ-017 ADD, one edge (E9): add the zero-extended Reminder; load Product; compute Match_Sig; set Done_Sig=1; go to DONE.
REQ-018 Done_Sig SHALL be high for exactly one clock cycle (the cycle after E9, i.e. 9 cycles after the start edge for DATA_W=8) and cleared at E10.
REQ-019 DONE SHALL go to HOLD unconditionally at E10.
REQ-020 HOLD SHALL return to IDLE on the first edge with Start_Sig=0; while Start_Sig stays 1, no new operation starts.
REQ-021 Product and Match_Sig SHALL hold their values until the next ADD state writes them.
REQ-022 Arithmetic SHALL be unsigned with a 2*DATA_W accumulator; the maximum result (2^DATA_W-1)^2 + (2^DATA_W-1) fits, so no overflow is possible.
REQ-023 Divisor=0 or Quotient=0 SHALL give Product equal to the zero-extended Reminder.
REQ-024 Input changes after E0 SHALL be ignored; only the latched operands are used.
REQ-025 Start_Sig falling during MUL or ADD SHALL NOT abort the operation; Done_Sig still pulses, then HOLD goes to IDLE at the next edge.
REQ-026 Match_Sig SHALL be 0 whenever the upper DATA_W bits of Product are nonzero.

Reset
REQ-027 RSTn=0, at any time including mid-operation, SHALL immediately set:
  - state IDLE;
  - Done_Sig=0, Match_Sig=0, Busy_Sig=0;
  - Product=0, accumulator=0, counter=0, latched operands=0.
REQ-028 After RSTn rises, the first start SHALL be accepted on the first edge with Start_Sig=1.

Verification
REQ-029 Q=44, D=5, R=0, Dividend=220, Start held until Done -> Done_Sig pulses 9 cycles after the start edge; Product=220; Match_Sig=1.
REQ-030 Q=255, D=255, R=255, Dividend=0 -> Product=65280; Match_Sig=0.
REQ-031 Q=7, D=0, R=9, Dividend=9 -> Product=9; Match_Sig=1.
REQ-032 Q=10, D=3, R=1, Dividend=30 -> Product=31; Match_Sig=0.
REQ-033 Start_Sig held high 20 cycles past Done -> one Done_Sig pulse only, Busy_Sig high until Start_Sig=0. Start_Sig low then high again -> new operation, second Done_Sig pulse.
REQ-034 RSTn pulsed low during MUL iteration 4 -> all outputs 0, Busy_Sig=0, and no Done_Sig. A subsequent start with Q=12, D=12, R=3 -> Product=147.
